// File: rtl/adc_result_avg_bcd.sv
// Averages 2^LOG2_N consecutive ADC samples and converts the average to
// 3-digit packed BCD with a sequential shift-add-3 engine.
module adc_result_avg_bcd #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LOG2_N = 2
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] avg_out,
  output logic [11:0]      bcd_out,
  output logic             result_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned ACC_W = WIDTH + LOG2_N;
  localparam int unsigned CNT_W = LOG2_N + 1;
  localparam int unsigned IT_W  = $clog2(WIDTH + 1);
  localparam int unsigned N     = 1 << LOG2_N;

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_CONV  = 1'b1
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_avg;
  logic [11:0]        r_scratch;
  logic [IT_W-1:0]    r_iter;

  logic [ACC_W-1:0]   w_sum;
  logic [WIDTH-1:0]   w_avg;
  logic               w_last_sample;
  logic               w_last_iter;
  logic [11:0]        w_adj;
  logic [11:0]        w_scratch_nxt;

  assign w_sum         = r_acc + ACC_W'(sample_in);
  assign w_avg         = WIDTH'(w_sum >> LOG2_N);
  assign w_last_sample = (r_cnt == CNT_W'(N - 1));
  assign w_last_iter   = (r_iter == IT_W'(WIDTH - 1));

  // Add-3 correction on every BCD digit that would overflow after doubling
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < 3; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_scratch_nxt = 12'({w_adj, r_shift[WIDTH-1]});

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      r_state      <= S_ACCUM;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_avg        <= '0;
      r_scratch    <= '0;
      r_iter       <= '0;
      avg_out      <= '0;
      bcd_out      <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (r_state)
        S_ACCUM: begin
          if (sample_valid) begin
            if (w_last_sample) begin
              r_shift   <= w_avg;
              r_avg     <= w_avg;
              r_scratch <= '0;
              r_iter    <= '0;
              r_acc     <= '0;
              r_cnt     <= '0;
              busy      <= 1'b1;
              r_state   <= S_CONV;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_CONV: begin
          // Samples arriving mid-conversion are discarded and flagged
          if (sample_valid) begin
            overrun <= 1'b1;
          end
          r_scratch <= w_scratch_nxt;
          r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
          r_iter    <= r_iter + IT_W'(1);
          if (w_last_iter) begin
            bcd_out      <= w_scratch_nxt;
            avg_out      <= r_avg;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            r_state      <= S_ACCUM;
          end
        end
        default: r_state <= S_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_result_avg_bcd.sv
// Directed bench for adc_result_avg_bcd: a sum/divide reference model is
// compared every cycle, plus literal expectations per scenario.
module tb_adc_result_avg_bcd;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned LOG2_N = 2;
  localparam int unsigned N      = 1 << LOG2_N;

  logic             CLOCK_50     = 1'b0;
  logic             rst          = 1'b0;
  logic [WIDTH-1:0] sample_in    = '0;
  logic             sample_valid = 1'b0;
  logic [WIDTH-1:0] avg_out;
  logic [11:0]      bcd_out;
  logic             result_valid;
  logic             busy;
  logic             overrun;

  adc_result_avg_bcd #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) dut (
    .CLOCK_50     (CLOCK_50),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .avg_out      (avg_out),
    .bcd_out      (bcd_out),
    .result_valid (result_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  // Reference model: running sum, divide on the Nth sample, then a busy
  // window of WIDTH cycles after which the result appears.
  int m_sum = 0, m_cnt = 0, m_left = 0, m_pend = 0, m_avg = 0, m_bcd = 0;
  bit m_busy = 1'b0, m_rv = 1'b0, m_over = 1'b0;

  always @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      m_sum = 0; m_cnt = 0; m_left = 0; m_pend = 0; m_avg = 0; m_bcd = 0;
      m_busy = 1'b0; m_rv = 1'b0; m_over = 1'b0;
    end else begin
      m_rv = 1'b0;
      if (m_busy) begin
        if (sample_valid) m_over = 1'b1;
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_avg  = m_pend;
          m_bcd  = to_bcd(m_pend);
          m_rv   = 1'b1;
        end
      end else if (sample_valid) begin
        m_sum += int'(sample_in);
        m_cnt++;
        if (m_cnt == N) begin
          m_pend = m_sum / N;
          m_sum  = 0;
          m_cnt  = 0;
          m_busy = 1'b1;
          m_left = WIDTH;
        end
      end
    end
  end

  always @(negedge CLOCK_50) begin
    if (cmp_en) begin
      check("model_avg_out", int'(avg_out), m_avg);
      check("model_bcd_out", int'(bcd_out), m_bcd);
      check("model_result_valid", int'(result_valid), int'(m_rv));
      check("model_busy", int'(busy), int'(m_busy));
      check("model_overrun", int'(overrun), int'(m_over));
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic send(input int v);
    sample_in    = WIDTH'(v);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  // Counts falling edges until result_valid, bounded
  task automatic wait_rv(input string name, input int exp_lat, input int exp_avg, input int exp_bcd);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
      n++;
    end
    check({name, "_rv_seen"}, int'(seen), 1);
    if (seen) begin
      check({name, "_latency"}, n, exp_lat);
      check({name, "_avg"}, int'(avg_out), exp_avg);
      check({name, "_bcd"}, int'(bcd_out), exp_bcd);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #2;
    cmp_en = 1'b1;
    check("reset_avg", int'(avg_out), 0);
    check("reset_bcd", int'(bcd_out), 0);
    check("reset_rv", int'(result_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b1;
    tick();

    send4(100, 101, 102, 103);
    wait_rv("avg101", 8, 101, 'h101);
    repeat (3) tick();

    send4(255, 255, 255, 255);
    wait_rv("max255", 8, 255, 'h255);
    check("max255_overrun", int'(overrun), 0);
    repeat (2) tick();

    send4(0, 0, 0, 3);
    wait_rv("trunc0", 8, 0, 'h000);
    tick();
    send4(9, 9, 9, 9);
    wait_rv("nine", 8, 9, 'h009);
    tick();

    send4(50, 50, 50, 50);
    send(200);
    wait_rv("drop_first", 7, 50, 'h050);
    check("drop_overrun_set", int'(overrun), 1);
    send4(50, 50, 50, 50);
    wait_rv("drop_second", 8, 50, 'h050);
    repeat (3) tick();
    check("drop_overrun_sticky", int'(overrun), 1);

    send4(77, 77, 77, 77);
    repeat (3) tick();
    check("midconv_busy_before", int'(busy), 1);
    rst = 1'b0;
    #1;
    check("midconv_avg", int'(avg_out), 0);
    check("midconv_bcd", int'(bcd_out), 0);
    check("midconv_busy", int'(busy), 0);
    check("midconv_overrun", int'(overrun), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      check("midconv_no_rv_in_reset", int'(result_valid), 0);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLOCK_50);
      check("midconv_no_rv_after", int'(result_valid), 0);
    end
    send4(10, 10, 10, 10);
    wait_rv("after_reset", 8, 10, 'h010);
    tick();

    send4(128, 128, 128, 128);
    wait_rv("b2b_first", 8, 128, 'h128);
    check("b2b_busy_in_rv", int'(busy), 0);
    send(64);
    send(64); send(64); send(64);
    wait_rv("b2b_second", 8, 64, 'h064);
    repeat (4) tick();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
